pipe_controller: RTL and testbench

Registered, parametrised successor to the processor's combinational decode controller. Decodes one 19-bit instruction per cycle into EX-stage control, holds the Zero/Carry flag register with EX→ID forwarding, resolves branches/jump/call/return in decode, and generates a counted flush window. It owns a parametrised return-address stack with sticky overflow/underflow reporting. It sits between instruction fetch and the datapath.

---
 rtl/pipe_controller_pkg.sv | 70 +++++++
 rtl/pipe_controller_if.sv | 40 ++++
 rtl/ret_addr_stack.sv | 51 +++++
 rtl/pipe_controller.sv | 128 ++++++++++++
 tb/tb_pipe_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_controller_pkg.sv
// Shared decode constants, ALU function codes, PC-select encodings and the EX control bundle
// for the pipelined decode controller.
package pipe_ctrl_pkg;

   localparam logic [1:0] OpAluReg = 2'b00;
   localparam logic [1:0] OpAluImm = 2'b01;
   localparam logic [2:0] OpMem    = 3'b100;
   localparam logic [2:0] OpBranch = 3'b101;
   localparam logic [2:0] OpShift  = 3'b110;
   localparam logic [4:0] OpJump   = 5'b11100;
   localparam logic [4:0] OpCall   = 5'b11101;
   localparam logic [5:0] OpRet    = 6'b111100;

   localparam logic [1:0] MemLoad  = 2'b00;
   localparam logic [1:0] MemStore = 2'b01;

   localparam logic [3:0] FnBubble = 4'b1000;
   localparam logic [3:0] FnLoad   = 4'b1000;

   typedef enum logic [1:0] {
      PcSelNext   = 2'b00,
      PcSelBranch = 2'b01,
      PcSelTarget = 2'b10
   } pc_sel_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       alu_b_sel;
      logic       sel_r2;
      logic       wb_sel;
      logic [3:0] alu_fn;
      logic       z_en;
      logic       c_en;
   } ex_ctrl_t;

   localparam ex_ctrl_t ExBubble = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                     alu_b_sel: 1'b0, sel_r2: 1'b0, wb_sel: 1'b0,
                                     alu_fn: FnBubble, z_en: 1'b0, c_en: 1'b0};

   // op is instr[18:13]; control-flow opcodes decode to a bubble here.
   function automatic ex_ctrl_t decode_ex(input logic [5:0] op);
      ex_ctrl_t c;
      c = ExBubble;
      if (op[5:4] == OpAluReg || op[5:4] == OpAluImm) begin
         c.alu_fn    = {1'b1, op[3:1]};
         c.reg_write = 1'b1;
         c.wb_sel    = 1'b1;
         c.z_en      = 1'b1;
         c.c_en      = 1'b1;
         c.alu_b_sel = op[4];
         c.sel_r2    = op[4];
      end else if (op[5:3] == OpShift) begin
         c.alu_fn    = {2'b00, op[2:1]};
         c.reg_write = 1'b1;
         c.wb_sel    = 1'b1;
         c.c_en      = 1'b1;
      end else if (op[5:3] == OpMem && op[2:1] == MemLoad) begin
         c.alu_fn    = FnLoad;
         c.mem_read  = 1'b1;
         c.reg_write = 1'b1;
      end else if (op[5:3] == OpMem && op[2:1] == MemStore) begin
         c.mem_write = 1'b1;
         c.sel_r2    = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// Fetch/datapath <-> decode-controller bundle. The controller takes the slave side.
interface pipe_controller_if #(
   parameter int unsigned INSTR_W = 19,
   parameter int unsigned ADDR_W  = 12
);
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [ADDR_W-1:0]  pc_plus1;
   logic               alu_zero;
   logic               alu_carry;

   logic               ex_reg_write;
   logic               ex_mem_read;
   logic               ex_mem_write;
   logic               ex_alu_b_sel;
   logic               ex_sel_r2;
   logic               ex_wb_sel;
   logic [3:0]         ex_alu_fn;
   logic [1:0]         pc_sel;
   logic [ADDR_W-1:0]  pc_target;
   logic               flush;
   logic               zero_flag;
   logic               carry_flag;
   logic               stack_overflow;
   logic               stack_underflow;

   modport master (
      output instr, instr_valid, pc_plus1, alu_zero, alu_carry,
      input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_b_sel, ex_sel_r2, ex_wb_sel,
             ex_alu_fn, pc_sel, pc_target, flush, zero_flag, carry_flag,
             stack_overflow, stack_underflow
   );

   modport slave (
      input  instr, instr_valid, pc_plus1, alu_zero, alu_carry,
      output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_b_sel, ex_sel_r2, ex_wb_sel,
             ex_alu_fn, pc_sel, pc_target, flush, zero_flag, carry_flag,
             stack_overflow, stack_underflow
   );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address stack with a saturating pointer; over-push and under-pop are ignored here
// and reported by the owner.
module ret_addr_stack #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 12
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int unsigned SpW  = $clog2(DEPTH + 1);
   localparam int unsigned IdxW = $clog2(DEPTH);

   logic [W-1:0]   mem_q [DEPTH];
   logic [SpW-1:0] sp_q, sp_d;
   logic [IdxW-1:0] top_idx;

   assign full_o  = (sp_q == SpW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign top_idx = IdxW'(sp_q - 1'b1);
   assign top_o   = empty_o ? '0 : mem_q[top_idx];

   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_o) begin
         sp_d = sp_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         sp_d = sp_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry contents are don't-care once the pointer is reset.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) begin
         mem_q[sp_q[IdxW-1:0]] <= din_i;
      end
   end
endmodule

// File: rtl/pipe_controller.sv
// Registered decode controller: EX control pipeline, Z/C flags with EX forwarding, decode-stage
// redirects, counted flush window and return-address stack with sticky error reporting.
module pipe_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned INSTR_W      = 19,
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned STACK_DEPTH  = 8,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input logic               clock,
   input logic               init_signal,
   pipe_controller_if.slave  bus
);
   localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

   ex_ctrl_t          ex_d, ex_q;
   logic [2:0]        flush_cnt_d, flush_cnt_q;
   logic              zero_q, carry_q, ovf_q, unf_q;
   logic              ovf_set, unf_set;
   logic              push, pop, stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top, pc_target;
   pc_sel_e           pc_sel;
   logic [5:0]        op;
   logic              live, taken, eff_z, eff_c;
   logic              unused_instr;

   assign op           = bus.instr[INSTR_W-1 -: 6];
   assign unused_instr = ^bus.instr[INSTR_W-7:ADDR_W];
   assign live         = bus.instr_valid && (flush_cnt_q == '0);
   // A flag-updating instruction in EX overrides the stale flag register.
   assign eff_z        = ex_q.z_en ? bus.alu_zero : zero_q;
   assign eff_c        = ex_q.c_en ? bus.alu_carry : carry_q;

   always_comb begin
      ex_d      = ExBubble;
      pc_sel    = PcSelNext;
      pc_target = '0;
      push      = 1'b0;
      pop       = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      taken     = 1'b0;
      if (live) begin
         ex_d = decode_ex(op);
         if (op[5:3] == OpBranch) begin
            case (op[2:1])
               2'b00:   taken = eff_z;
               2'b01:   taken = !eff_z;
               2'b10:   taken = eff_c;
               default: taken = !eff_c;
            endcase
            if (taken) begin
               pc_sel    = PcSelBranch;
               pc_target = bus.instr[ADDR_W-1:0];
            end
         end else if (op[5:1] == OpJump || op[5:1] == OpCall) begin
            pc_sel    = PcSelTarget;
            pc_target = bus.instr[ADDR_W-1:0];
            if (op[5:1] == OpCall) begin
               push    = !stk_full;
               ovf_set = stk_full;
            end
         end else if (op == OpRet) begin
            pc_sel    = PcSelTarget;
            pc_target = stk_top;
            pop       = !stk_empty;
            unf_set   = stk_empty;
         end
      end
   end

   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (pc_sel != PcSelNext) begin
         flush_cnt_d = FlushLoad;
      end else if (flush_cnt_q != '0) begin
         flush_cnt_d = flush_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge init_signal) begin
      if (init_signal) begin
         ex_q        <= ExBubble;
         flush_cnt_q <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         ex_q        <= ex_d;
         flush_cnt_q <= flush_cnt_d;
         if (ex_q.z_en) zero_q  <= bus.alu_zero;
         if (ex_q.c_en) carry_q <= bus.alu_carry;
         ovf_q       <= ovf_q | ovf_set;
         unf_q       <= unf_q | unf_set;
      end
   end

   ret_addr_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .clk_i   (clock),
      .rst_i   (init_signal),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (bus.pc_plus1),
      .top_o   (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   assign bus.ex_reg_write    = ex_q.reg_write;
   assign bus.ex_mem_read     = ex_q.mem_read;
   assign bus.ex_mem_write    = ex_q.mem_write;
   assign bus.ex_alu_b_sel    = ex_q.alu_b_sel;
   assign bus.ex_sel_r2       = ex_q.sel_r2;
   assign bus.ex_wb_sel       = ex_q.wb_sel;
   assign bus.ex_alu_fn       = ex_q.alu_fn;
   assign bus.pc_sel          = pc_sel;
   assign bus.pc_target       = pc_target;
   assign bus.flush           = (flush_cnt_q != '0);
   assign bus.zero_flag       = zero_q;
   assign bus.carry_flag      = carry_q;
   assign bus.stack_overflow  = ovf_q;
   assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: decode table, forwarding, flush, stack and async reset.
module tb_pipe_controller;
   localparam logic [18:0] InsAluReg = 19'h0C000;  // 00_011 -> fn 1011
   localparam logic [18:0] InsBz     = 19'h50055;  // 101_00, target 0x055
   localparam logic [18:0] InsBnz    = 19'h54055;  // 101_01, target 0x055
   localparam logic [18:0] InsCall   = 19'h74400;  // 11101, target 0x400
   localparam logic [18:0] InsRet    = 19'h78000;  // 111100
   localparam logic [18:0] InsJmp    = 19'h702AB;  // 11100, target 0x2AB

   logic clk = 1'b0;
   logic rst, rst3;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   pipe_controller_if #(.INSTR_W(19), .ADDR_W(12)) if1 ();
   pipe_controller_if #(.INSTR_W(19), .ADDR_W(12)) if3 ();

   pipe_controller #(
      .INSTR_W(19), .ADDR_W(12), .STACK_DEPTH(8), .FLUSH_CYCLES(1)
   ) u_dut (
      .clock       (clk),
      .init_signal (rst),
      .bus         (if1.slave)
   );

   pipe_controller #(
      .INSTR_W(19), .ADDR_W(12), .STACK_DEPTH(8), .FLUSH_CYCLES(3)
   ) u_dut3 (
      .clock       (clk),
      .init_signal (rst3),
      .bus         (if3.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic [18:0] ins, input logic v);
      if1.instr       = ins;
      if1.instr_valid = v;
   endtask

   // Decode table: instr, fn, {reg_write, mem_read, mem_write, b_sel, sel_r2, wb_sel}
   logic [18:0] vec_ins [5] = '{19'h28000, 19'h40000, 19'h44000, 19'h6C000, 19'h7C000};
   logic [3:0]  vec_fn  [5] = '{4'b1010,   4'b1000,   4'b1000,   4'b0011,   4'b1000};
   logic [5:0]  vec_ctl [5] = '{6'b100111, 6'b110000, 6'b001010, 6'b100001, 6'b000000};

   initial begin
      rst  = 1'b1;
      rst3 = 1'b1;
      drive1('0, 1'b0);
      if1.pc_plus1 = '0; if1.alu_zero = 1'b0; if1.alu_carry = 1'b0;
      if3.instr = '0; if3.instr_valid = 1'b0; if3.pc_plus1 = '0;
      if3.alu_zero = 1'b0; if3.alu_carry = 1'b0;
      repeat (2) step();

      check_eq("rst_fn", {28'd0, if1.ex_alu_fn}, 32'h8);
      check_eq("rst_ctl", {26'd0, if1.ex_reg_write, if1.ex_mem_read, if1.ex_mem_write,
                           if1.ex_alu_b_sel, if1.ex_sel_r2, if1.ex_wb_sel}, 32'h0);
      check_eq("rst_flags", {30'd0, if1.zero_flag, if1.carry_flag}, 32'h0);
      check_eq("rst_flush_err", {29'd0, if1.flush, if1.stack_overflow, if1.stack_underflow}, 0);
      rst  = 1'b0;
      rst3 = 1'b0;
      step();

      // ALU reg then idle; flags latch from the EX cycle.
      drive1(InsAluReg, 1'b1);
      #1 check_eq("alu_pcsel", {30'd0, if1.pc_sel}, 32'h0);
      step();
      check_eq("alu_fn", {28'd0, if1.ex_alu_fn}, 32'hB);
      check_eq("alu_rw_wb", {30'd0, if1.ex_reg_write, if1.ex_wb_sel}, 32'h3);
      drive1('0, 1'b0);
      if1.alu_zero = 1'b1;
      step();
      check_eq("alu_zflag", {31'd0, if1.zero_flag}, 32'h1);
      check_eq("alu_cflag", {31'd0, if1.carry_flag}, 32'h0);
      check_eq("idle_fn", {28'd0, if1.ex_alu_fn}, 32'h8);
      if1.alu_zero = 1'b0;

      // Decode table; ALU imm in EX with alu_zero=0 clears the Z flag.
      for (int i = 0; i < 5; i++) begin
         drive1(vec_ins[i], 1'b1);
         step();
         check_eq($sformatf("dec%0d_fn", i), {28'd0, if1.ex_alu_fn}, {28'd0, vec_fn[i]});
         check_eq($sformatf("dec%0d_ctl", i),
                  {26'd0, if1.ex_reg_write, if1.ex_mem_read, if1.ex_mem_write,
                   if1.ex_alu_b_sel, if1.ex_sel_r2, if1.ex_wb_sel}, {26'd0, vec_ctl[i]});
      end
      check_eq("zflag_cleared", {31'd0, if1.zero_flag}, 32'h0);

      // Forwarded BZ, then flush and squashed instruction.
      drive1(InsAluReg, 1'b1);
      step();
      drive1(InsBz, 1'b1);
      if1.alu_zero = 1'b1;
      #1 check_eq("bz_pcsel", {30'd0, if1.pc_sel}, 32'h1);
      check_eq("bz_target", {20'd0, if1.pc_target}, 32'h055);
      check_eq("bz_zreg", {31'd0, if1.zero_flag}, 32'h0);
      step();
      if1.alu_zero = 1'b0;
      check_eq("bz_flush", {31'd0, if1.flush}, 32'h1);
      check_eq("bz_zflag", {31'd0, if1.zero_flag}, 32'h1);
      drive1(InsAluReg, 1'b1);
      #1 check_eq("sq_pcsel", {30'd0, if1.pc_sel}, 32'h0);
      step();
      check_eq("sq_fn", {28'd0, if1.ex_alu_fn}, 32'h8);
      check_eq("sq_rw", {31'd0, if1.ex_reg_write}, 32'h0);
      check_eq("sq_flush_end", {31'd0, if1.flush}, 32'h0);
      drive1(InsBnz, 1'b1);
      #1 check_eq("bnz_untaken", {18'd0, if1.pc_sel, if1.pc_target}, 32'h0);
      step();
      check_eq("bnz_noflush", {31'd0, if1.flush}, 32'h0);

      // Call then return.
      if1.pc_plus1 = 12'h123;
      drive1(InsCall, 1'b1);
      #1 check_eq("call_pcsel", {30'd0, if1.pc_sel}, 32'h2);
      check_eq("call_target", {20'd0, if1.pc_target}, 32'h400);
      step();
      drive1('0, 1'b0);
      step();
      drive1(InsRet, 1'b1);
      #1 check_eq("ret_pcsel", {30'd0, if1.pc_sel}, 32'h2);
      check_eq("ret_target", {20'd0, if1.pc_target}, 32'h123);
      step();
      drive1('0, 1'b0);
      step();
      check_eq("ret_no_unf", {31'd0, if1.stack_underflow}, 32'h0);

      // Nine nested calls into an eight-deep stack.
      for (int i = 1; i <= 9; i++) begin
         if1.pc_plus1 = 12'(i);
         drive1(InsCall, 1'b1);
         step();
         drive1('0, 1'b0);
         step();
         if (i == 8) check_eq("ovf_before", {31'd0, if1.stack_overflow}, 32'h0);
      end
      check_eq("ovf_set", {31'd0, if1.stack_overflow}, 32'h1);
      for (int i = 8; i >= 1; i--) begin
         drive1(InsRet, 1'b1);
         #1 check_eq($sformatf("pop%0d", i), {20'd0, if1.pc_target}, i);
         step();
         drive1('0, 1'b0);
         step();
      end
      drive1(InsRet, 1'b1);
      #1 check_eq("unf_pcsel", {30'd0, if1.pc_sel}, 32'h2);
      check_eq("unf_target", {20'd0, if1.pc_target}, 32'h0);
      step();
      drive1('0, 1'b0);
      check_eq("unf_set", {31'd0, if1.stack_underflow}, 32'h1);
      repeat (2) step();
      check_eq("errs_sticky", {30'd0, if1.stack_overflow, if1.stack_underflow}, 32'h3);

      // Three-cycle flush window interrupted by reset.
      if3.instr = InsAluReg; if3.instr_valid = 1'b1;
      step();
      if3.instr = InsJmp;
      if3.alu_zero = 1'b1;
      #1 check_eq("jmp_target", {18'd0, if3.pc_sel, if3.pc_target}, {18'd0, 2'b10, 12'h2AB});
      step();
      if3.instr = '0; if3.instr_valid = 1'b0; if3.alu_zero = 1'b0;
      check_eq("jmp_flush1", {30'd0, if3.flush, if3.zero_flag}, 32'h3);
      step();
      check_eq("jmp_flush2", {31'd0, if3.flush}, 32'h1);
      #2 rst3 = 1'b1;
      #1 check_eq("rst3_flush", {31'd0, if3.flush}, 32'h0);
      check_eq("rst3_state", {26'd0, if3.ex_alu_fn, if3.zero_flag, if3.carry_flag}, 32'h20);
      check_eq("rst3_pcsel", {30'd0, if3.pc_sel}, 32'h0);
      rst3 = 1'b0;
      step();
      check_eq("rst3_after", {31'd0, if3.flush}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
